// File: rtl/mmio_gpio.sv
// mmio_gpio: bus-mapped GPIO with OUT/TGL, synchronised IN, W1C change flags and a masked level irq
`timescale 1ns/1ps
module mmio_gpio #(
  parameter logic [15:0] BASE_ADDR = 16'hC000,
  parameter int OUT_W = 10,
  parameter int IN_W = 10,
  parameter logic [OUT_W-1:0] OUT_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      addr,
  input  logic             we,
  input  logic             re,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata,
  output logic             hit,
  input  logic [IN_W-1:0]  gpio_in,
  output logic [OUT_W-1:0] gpio_out,
  output logic             irq
);
  logic [OUT_W-1:0] out_r;
  logic [IN_W-1:0] s1, in_s, in_p, chg, ien;
  logic [4:0] sel;
  logic unused_ok;
  always_comb begin
    for (int i = 0; i < 5; i++) sel[i] = addr == BASE_ADDR + 16'(i);
    hit = |sel;
    rdata = !re ? '0 : sel[0] ? 16'(out_r) : sel[1] ? 16'(in_s) : sel[2] ? 16'(chg) : sel[3] ? 16'(ien) : '0;
    gpio_out = out_r;
    irq = |(chg & ien);
    unused_ok = ^wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= OUT_RST;
      s1 <= '0;
      in_s <= '0;
      in_p <= '0;
      chg <= '0;
      ien <= '0;
    end else begin
      out_r <= we && sel[0] ? wdata[OUT_W-1:0] : we && sel[4] ? out_r ^ wdata[OUT_W-1:0] : out_r;
      s1 <= gpio_in;
      in_s <= s1;
      in_p <= in_s;
      chg <= (chg & ~(we && sel[2] ? wdata[IN_W-1:0] : '0)) | (in_s ^ in_p);
      ien <= we && sel[3] ? wdata[IN_W-1:0] : ien;
    end
  end
endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: directed and randomized checks of mmio_gpio against a behavioural model
`timescale 1ns/1ps
module tb_mmio_gpio;
  logic clk = 0, rst = 1, we = 0, re = 0;
  logic [15:0] addr = 0, wdata = 0;
  logic [9:0] gpio_in = 0;
  logic [15:0] rdata, rdata2;
  logic hit, hit2, irq, irq2;
  logic [9:0] gpio_out;
  logic [3:0] gpio_out2;
  int passed = 0, total = 0;
  logic [9:0] m_out, m_chg, m_ien;
  logic [9:0] hist [3];
  bit m_valid = 0;
  int off;
  logic [15:0] er;
  bit eh;

  always #5 clk = ~clk;

  mmio_gpio #(.BASE_ADDR(16'hC000), .OUT_W(10), .IN_W(10), .OUT_RST(10'h155)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .wdata(wdata),
    .rdata(rdata), .hit(hit), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq));

  mmio_gpio #(.BASE_ADDR(16'hC010), .OUT_W(4), .IN_W(10), .OUT_RST(4'h0)) dut2 (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .wdata(wdata),
    .rdata(rdata2), .hit(hit2), .gpio_in(gpio_in), .gpio_out(gpio_out2), .irq(irq2));

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask

  // hist holds gpio_in as seen at the last three edges, newest first:
  // [0] is the first sync stage, [1] the synchronised value, [2] the value before that
  always @(posedge clk) begin
    if (rst) begin
      m_out <= 10'h155;
      m_chg <= '0;
      m_ien <= '0;
      hist <= '{default: '0};
      m_valid <= 1;
    end else begin
      hist <= '{gpio_in, hist[0], hist[1]};
      if (we && addr == 16'hC000) m_out <= wdata[9:0];
      if (we && addr == 16'hC004) m_out <= m_out ^ wdata[9:0];
      if (we && addr == 16'hC003) m_ien <= wdata[9:0];
      m_chg <= (m_chg & ~((we && addr == 16'hC002) ? wdata[9:0] : 10'h0)) | (hist[1] ^ hist[2]);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      off = int'(addr) - 32'hC000;
      eh = off >= 0 && off <= 4;
      er = !(re && eh) ? 16'h0 : off == 0 ? {6'h0, m_out} : off == 1 ? {6'h0, hist[1]} :
           off == 2 ? {6'h0, m_chg} : off == 3 ? {6'h0, m_ien} : 16'h0;
      chk("cyc_gpio_out", {6'h0, gpio_out}, {6'h0, m_out});
      chk("cyc_irq", {15'h0, irq}, {15'h0, |(m_chg & m_ien)});
      chk("cyc_hit", {15'h0, hit}, {15'h0, eh});
      chk("cyc_rdata", rdata, er);
    end
  end

  task automatic bus(input logic [15:0] a, input logic w, input logic r, input logic [15:0] d);
    @(posedge clk);
    #2;
    addr = a; we = w; re = r; wdata = d;
    #1;
  endtask

  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    bus(16'hC002, 0, 1, 0);
    chk("rst_gpio_out", {6'h0, gpio_out}, 16'h0155);
    chk("rst_irq", {15'h0, irq}, 16'h0);
    chk("rst_chg", rdata, 16'h0000);
    bus(16'hC003, 0, 1, 0);
    chk("rst_ien", rdata, 16'h0000);
    bus(16'hC000, 1, 0, 16'hFFFF);
    bus(16'hC000, 0, 1, 0);
    chk("out_rd", rdata, 16'h03FF);
    chk("out_pin", {6'h0, gpio_out}, 16'h03FF);
    bus(16'hC004, 1, 0, 16'h000F);
    bus(16'hC004, 0, 1, 0);
    chk("tgl_rd", rdata, 16'h0000);
    chk("tgl_pin", {6'h0, gpio_out}, 16'h03F0);
    bus(16'h0000, 0, 0, 0);
    gpio_in = 10'h001;
    bus(16'hC001, 0, 1, 0);
    chk("in_k", rdata, 16'h0000);
    bus(16'hC001, 0, 1, 0);
    chk("in_k1", rdata, 16'h0001);
    bus(16'hC002, 0, 1, 0);
    chk("chg_k2", rdata, 16'h0001);
    bus(16'hC002, 1, 0, 16'hFFFF);
    bus(16'hC003, 1, 0, 16'h0001);
    bus(16'h0000, 0, 0, 0);
    chk("irq_idle", {15'h0, irq}, 16'h0);
    gpio_in = 10'h000;
    bus(16'h0000, 0, 0, 0);
    chk("irq_k", {15'h0, irq}, 16'h0);
    bus(16'h0000, 0, 0, 0);
    chk("irq_k1", {15'h0, irq}, 16'h0);
    bus(16'h0000, 0, 0, 0);
    chk("irq_k2", {15'h0, irq}, 16'h1);
    bus(16'hC002, 1, 0, 16'h0000);
    bus(16'h0000, 0, 0, 0);
    chk("w0c_keeps_irq", {15'h0, irq}, 16'h1);
    bus(16'hC002, 1, 0, 16'h0001);
    bus(16'h0000, 0, 0, 0);
    chk("w1c_drops_irq", {15'h0, irq}, 16'h0);
    gpio_in = 10'h008;
    bus(16'h0000, 0, 0, 0);
    bus(16'hC002, 1, 0, 16'h0008);
    bus(16'hC002, 0, 1, 0);
    chk("set_beats_clear", rdata, 16'h0008);
    bus(16'hC002, 1, 0, 16'h0008);
    bus(16'hC002, 0, 1, 0);
    chk("w1c_bit3", rdata, 16'h0000);
    bus(16'hBFFF, 1, 1, 16'hFFFF);
    chk("below_hit", {15'h0, hit}, 16'h0);
    chk("below_rd", rdata, 16'h0000);
    bus(16'hC005, 1, 1, 16'hFFFF);
    chk("above_hit", {15'h0, hit}, 16'h0);
    chk("above_rd", rdata, 16'h0000);
    bus(16'hC000, 0, 1, 0);
    chk("decode_out", rdata, 16'h03F0);
    bus(16'hC003, 0, 1, 0);
    chk("decode_ien", rdata, 16'h0001);
    bus(16'hC010, 1, 0, 16'hFFFF);
    bus(16'hC010, 0, 1, 0);
    chk("b2_rd", rdata2, 16'h000F);
    chk("b2_pin", {12'h0, gpio_out2}, 16'h000F);
    chk("b2_hit", {15'h0, hit2}, 16'h1);
    chk("b2_other_rd", rdata, 16'h0000);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      rst = $urandom_range(0, 99) == 0;
      addr = 16'($urandom_range(32'hBFFF, 32'hC005));
      we = $urandom_range(0, 1) == 1;
      re = $urandom_range(0, 1) == 1;
      wdata = 16'($urandom);
      if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ 10'($urandom);
    end
    @(posedge clk);
    #2 rst = 0; we = 0; re = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
